// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//
// Owns the COLS x ROWS monochrome framebuffer read by the VGA scanout block.
// Two pixel-drawing requesters share write access through valid/ready
// handshakes with round-robin arbitration. Supported commands are
// clear/set/toggle of a single pixel and a multi-cycle clear-all that wipes
// one row per cycle.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   vblank            vertical blanking level from the VGA timing block
//   reqN_valid        requester N presents a command
//   reqN_ready        requester N's command is taken this cycle (valid & ready)
//   reqN_x, reqN_y    pixel column / row
//   reqN_op           00 clear pixel, 01 set pixel, 10 toggle pixel, 11 clear-all
//   data              framebuffer to scanout, pixel (x,y) = bit y*COLS+x
//   busy              high while the clear-all sequence runs
//   oob               one-cycle pulse after an out-of-range pixel op is taken
//
// Optional build macro FB_VSYNC_COMMIT_EN:
//   When defined, writes land in a shadow buffer and data is a separate front
//   buffer that is refreshed from the shadow once per vertical blanking
//   interval. When undefined, data is the write buffer itself and vblank is
//   ignored.

module fb_write_arbiter #(
   parameter int COLS = 40,
   parameter int ROWS = 30,
   parameter int XW   = 6,
   parameter int YW   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vblank,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [XW-1:0]        req0_x,
   input  logic [YW-1:0]        req0_y,
   input  logic [1:0]           req0_op,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [XW-1:0]        req1_x,
   input  logic [YW-1:0]        req1_y,
   input  logic [1:0]           req1_op,
   output logic [COLS*ROWS-1:0] data,
   output logic                 busy,
   output logic                 oob
);

   localparam int N  = COLS * ROWS;
   localparam int IW = $clog2(N);

   localparam logic [1:0] OP_CLR = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_TGL = 2'b10;
   localparam logic [1:0] OP_ALL = 2'b11;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t state, state_next;

   logic          favour1;
   logic [YW-1:0] row;
   logic [N-1:0]  wbuf;

   logic          acc0, acc1, acc;
   logic [XW-1:0] sel_x;
   logic [YW-1:0] sel_y;
   logic [1:0]    sel_op;
   logic          in_range;
   logic [IW-1:0] pix_idx;
   logic [IW-1:0] row_base;

   // Grant logic. A lone valid requester always wins; on contention the
   // requester favoured by the round-robin pointer wins. Nothing is granted
   // during reset or while a clear-all sequence owns the buffer.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst && state == IDLE) begin
         req0_ready = req0_valid && (!req1_valid || !favour1);
         req1_ready = req1_valid && (!req0_valid ||  favour1);
      end
   end

   assign acc0 = req0_valid && req0_ready;
   assign acc1 = req1_valid && req1_ready;
   assign acc  = acc0 || acc1;

   // At most one requester is granted, so the accepted command is a plain mux.
   assign sel_x  = acc1 ? req1_x  : req0_x;
   assign sel_y  = acc1 ? req1_y  : req0_y;
   assign sel_op = acc1 ? req1_op : req0_op;

   assign in_range = (int'(sel_x) < COLS) && (int'(sel_y) < ROWS);

   // The index is only used when in_range holds, so truncation is harmless.
   assign pix_idx  = IW'(int'(sel_y) * COLS + int'(sel_x));
   assign row_base = IW'(int'(row) * COLS);

   // Next-state logic: a clear-all takes exactly ROWS cycles, one row each.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (acc && sel_op == OP_ALL) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            if (row == YW'(ROWS - 1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   assign busy = (state == CLEAR);

   // Round-robin pointer, clear row counter and out-of-range pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         favour1 <= 1'b0;
         row     <= '0;
         oob     <= 1'b0;
      end else begin
         oob <= acc && (sel_op != OP_ALL) && !in_range;
         if (acc0) begin
            favour1 <= 1'b1;
         end else if (acc1) begin
            favour1 <= 1'b0;
         end
         if (state == CLEAR) begin
            row <= row + 1'b1;
         end else if (acc && sel_op == OP_ALL) begin
            row <= '0;
         end
      end
   end

   // Write buffer. Out-of-range pixel ops complete the handshake but leave
   // the image untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbuf <= '0;
      end else if (state == CLEAR) begin
         wbuf[row_base +: COLS] <= '0;
      end else if (acc && sel_op != OP_ALL && in_range) begin
         case (sel_op)
            OP_CLR:  wbuf[pix_idx] <= 1'b0;
            OP_SET:  wbuf[pix_idx] <= 1'b1;
            OP_TGL:  wbuf[pix_idx] <= ~wbuf[pix_idx];
            default: wbuf[pix_idx] <= wbuf[pix_idx];
         endcase
      end
   end

`ifdef FB_VSYNC_COMMIT_EN
   logic vblank_q;
   logic commit_pend;

   // A vblank rise arms a commit. The copy happens on the first IDLE cycle
   // while vblank is still high; if a clear-all outlasts the blanking
   // interval the commit is abandoned for this frame. A write taken in the
   // commit cycle lands in the shadow only and shows up at the next vblank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vblank_q    <= 1'b0;
         commit_pend <= 1'b0;
         data        <= '0;
      end else begin
         vblank_q <= vblank;
         if (vblank && !vblank_q) begin
            commit_pend <= 1'b1;
         end else if (commit_pend && state == IDLE) begin
            if (vblank) begin
               data <= wbuf;
            end
            commit_pend <= 1'b0;
         end
      end
   end
`else
   logic unused_vblank;

   assign data          = wbuf;
   assign unused_vblank = vblank;
`endif

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
Owns the 40x30 monochrome framebuffer that the VGA scanout block reads as its flat `data` vector. It shares write access between two pixel-drawing requesters using valid/ready handshakes and round-robin arbitration. It supports set, clear and toggle of single pixels, plus a multi-cycle clear-all sequence. Sits between the drawing logic and the VGA timing/scanout block.

Parameters:
COLS, 40, framebuffer width in pixels
ROWS, 30, framebuffer height in pixels
XW, 6, x coordinate width (must satisfy 2^XW >= COLS)
YW, 5, y coordinate width (must satisfy 2^YW >= ROWS)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous reset, active-high
vblank  in  1  vertical blanking level from the VGA timing block
req0_valid  in  1  requester 0 has a command
req0_ready  out  1  requester 0 command accepted this cycle when valid&ready
req0_x  in  XW  pixel column
req0_y  in  YW  pixel row
req0_op  in  2  00 clear pixel, 01 set pixel, 10 toggle pixel, 11 clear-all
req1_valid, req1_ready, req1_x, req1_y, req1_op  same as req0, for requester 1
data  out  COLS*ROWS  framebuffer to scanout; pixel (x,y) = bit y*COLS+x
busy  out  1  high while in CLEAR state
oob  out  1  one-cycle pulse when an accepted pixel op has x>=COLS or y>=ROWS

Behaviour:
- Reset (asynchronous, immediate): data=0, state=IDLE, rr pointer favours req0, busy=0, oob=0, row counter=0. reqN_ready=0 while rst is high.
- States: IDLE and CLEAR.
- IDLE, grant logic: reqN_ready is combinational.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester favoured by the rr pointer gets ready=1; the other gets 0.
- Acceptance: valid&ready at a clock edge.
  - The rr pointer flips to favour the other requester after an acceptance.
  - The pointer is unchanged on idle cycles.
- Pixel op (00/01/10) accepted:
  - The bit updates on the accepting edge, so it is visible on data the next cycle (latency 1).
  - Back-to-back accepts are allowed every cycle.
- Out-of-range pixel op:
  - Accepted (the handshake completes); data is unchanged.
  - oob=1 for exactly the following cycle.
- Clear-all (11) accepted:
  - x and y are ignored; go to CLEAR with row counter=0.
  - busy and both readys go low from the next cycle.
- CLEAR:
  - Each cycle zeroes row[row counter] (COLS bits) and increments the counter.
  - After row ROWS-1 is cleared, return to IDLE.
  - Exactly ROWS cycles in CLEAR; ready can reassert on cycle ROWS+1 after acceptance.
  - Requests held valid during CLEAR stay pending and are served in rr order afterwards.
- Requester rule: a requester must hold x/y/op stable while valid and not ready. The arbiter never drops a held request.
- Reset mid-CLEAR: immediately IDLE with data all zero.
- vblank is unused in the base build.

Optional Feature:
FB_VSYNC_COMMIT_EN
- Defined:
  - Writes and clears target an internal shadow buffer.
  - data is a separate front buffer.
  - A rising edge of vblank (registered edge detect) sets commit-pending.
  - Commit copies shadow to front in one cycle. It occurs on the first cycle with commit-pending set, state=IDLE and vblank still high; commit-pending then clears.
  - A write accepted in the commit cycle is not included; it appears at the next vblank.
  - A vblank rise during CLEAR defers the commit until CLEAR ends. If vblank has fallen by then, the commit is dropped for that frame.
  - Reset clears shadow, front and commit-pending.
- Undefined: single buffer; writes appear on data with latency 1 as above.

Test Plan:
- Reset then idle -> data=0, req0_ready=req1_ready=0 during rst, busy=0.
- req0 set (x=5,y=2) -> bit 85 high one cycle after accept; toggle same pixel -> bit 85 low.
- Both valid continuously for 4 ops each (req0 set (0,0..3), req1 set (39,0..3)) -> grants alternate 0,1,0,1...; bits 0,40,80,120 and 39,79,119,159 set.
- Fill all pixels then req1 clear-all with req0 held valid -> busy high exactly 30 cycles; data=0 after; req0 granted on first IDLE cycle.
- req0 set (x=40,y=0) and (x=0,y=30) -> both accepted, oob pulses once each, data unchanged.
- With FB_VSYNC_COMMIT_EN: set (1,1) while vblank=0 -> data bit 41 stays 0; raise vblank -> bit 41 high within 2 cycles; assert rst mid-CLEAR -> data=0 immediately.
